// File: rtl/result_readout.sv
// result_readout: waits for all cores to finish, then streams the result matrix out as bytes, high byte first.
module result_readout #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [ADDR_W-1:0]    res_base,
    input  logic [ADDR_W-1:0]    res_count,
    output logic                 mem_sel,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_dout,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 done
);
    typedef enum logic [2:0] {IDLE, START, READ, CAPTURE, SEND_HI, SEND_LO, FINISH} state_t;
    state_t               state;
    logic [NUM_CORES-1:0] done_seen;
    logic [ADDR_W-1:0]    ptr;
    logic [ADDR_W-1:0]    remaining;
    logic [7:0]           word_lo;
    logic                 all_done;
    assign all_done = &(done_seen | core_done);
    assign mem_addr = mem_sel ? ptr : '0;
    // Only the low byte needs storing: the high byte goes straight to tx_data on capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            done_seen <= '0;
            ptr       <= '0;
            remaining <= '0;
            word_lo   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            mem_sel   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_seen <= done_seen | core_done;
                    if (all_done) begin
                        state   <= START;
                        mem_sel <= 1'b1;
                    end
                end
                START: begin
                    ptr       <= res_base;
                    remaining <= res_count;
                    if (res_count == '0) begin
                        state   <= FINISH;
                        mem_sel <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    word_lo  <= mem_dout[7:0];
                    tx_data  <= mem_dout[15:8];
                    tx_valid <= 1'b1;
                    state    <= SEND_HI;
                end
                SEND_HI: if (tx_ready) begin
                    tx_data <= word_lo;
                    state   <= SEND_LO;
                end
                SEND_LO: if (tx_ready) begin
                    ptr       <= ptr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                    tx_valid  <= 1'b0;
                    if (remaining == ADDR_W'(1)) begin
                        state   <= FINISH;
                        mem_sel <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                FINISH: state <= FINISH;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_readout.sv
// tb_result_readout: directed checks of result_readout against a registered-RAM model.
module tb_result_readout;
    logic        clock = 0;
    logic        reset = 1;
    logic [3:0]  core_done = 0;
    logic [7:0]  res_base = 0;
    logic [7:0]  res_count = 0;
    logic        mem_sel;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout = 0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1;
    logic        done;
    logic [15:0] mem [256];
    logic [7:0]  bytes_q[$];
    logic [7:0]  addr_q[$];
    int          passed = 0;
    int          total = 0;

    result_readout #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset(reset), .core_done(core_done), .res_base(res_base),
        .res_count(res_count), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_dout <= mem[mem_addr];
        if (!reset && tx_valid && tx_ready) begin
            bytes_q.push_back(tx_data);
            addr_q.push_back(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        step(1);
        reset = 0;
        bytes_q.delete();
        addr_q.delete();
    endtask

    task automatic trig(input logic [3:0] bits);
        core_done = bits;
        step(1);
        core_done = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && !done; i++) step(1);
        chk(tag, done, 1);
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] exp [$]);
        chk({tag, "_len"}, bytes_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < bytes_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), bytes_q[i], exp[i]);
    endtask

    initial begin
        logic bad;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem[8'h20] = 16'h1234; mem[8'h21] = 16'hABCD;
        mem[8'hFE] = 16'h0001; mem[8'hFF] = 16'h0002; mem[8'h00] = 16'h0003;
        mem[8'h40] = 16'h1111; mem[8'h41] = 16'h2222; mem[8'h42] = 16'h3333; mem[8'h43] = 16'h4444;
        step(2);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_done", done, 0);

        // 1: staggered single-cycle pulses, ready tied high
        do_reset();
        res_base = 8'h20; res_count = 2; tx_ready = 1;
        trig(4'b0001); step(3);
        trig(4'b0010);
        trig(4'b0100); step(4);
        chk("t1_idle_sel", mem_sel, 0);
        chk("t1_idle_valid", tx_valid, 0);
        trig(4'b1000);
        chk("t1_start_sel", mem_sel, 1);
        chk("t1_start_valid", tx_valid, 0);
        step(1);
        chk("t1_read_addr", mem_addr, 8'h20);
        step(1);
        chk("t1_capture_valid", tx_valid, 0);
        step(1);
        chk("t1_hi0_valid", tx_valid, 1);
        chk("t1_hi0_data", tx_data, 8'h12);
        step(1);
        chk("t1_lo0_data", tx_data, 8'h34);
        step(1);
        chk("t1_read1_valid", tx_valid, 0);
        chk("t1_read1_addr", mem_addr, 8'h21);
        step(2);
        chk("t1_hi1_data", tx_data, 8'hAB);
        step(1);
        chk("t1_lo1_data", tx_data, 8'hCD);
        chk("t1_lo1_done", done, 0);
        step(1);
        chk("t1_done", done, 1);
        chk("t1_done_sel", mem_sel, 0);
        chk("t1_done_valid", tx_valid, 0);
        chk_bytes("t1", '{8'h12, 8'h34, 8'hAB, 8'hCD});

        // 2: backpressure for 5 cycles at each high byte
        do_reset();
        tx_ready = 0;
        trig(4'hF);
        step(3);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid !== 1 || tx_data !== 8'h12) bad = 1;
            if (i < 4) step(1);
        end
        chk("t2_stall0_held", bad, 0);
        tx_ready = 1;
        step(1);
        chk("t2_lo0_data", tx_data, 8'h34);
        step(1);
        tx_ready = 0;
        step(2);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid !== 1 || tx_data !== 8'hAB) bad = 1;
            if (i < 4) step(1);
        end
        chk("t2_stall1_held", bad, 0);
        tx_ready = 1;
        step(1);
        chk("t2_lo1_data", tx_data, 8'hCD);
        step(1);
        chk("t2_done", done, 1);
        chk_bytes("t2", '{8'h12, 8'h34, 8'hAB, 8'hCD});

        // 3: zero-length result
        do_reset();
        res_count = 0;
        trig(4'hF);
        chk("t3_start_sel", mem_sel, 1);
        chk("t3_start_done", done, 0);
        step(1);
        chk("t3_done", done, 1);
        chk("t3_sel_low", mem_sel, 0);
        step(5);
        chk("t3_done_held", done, 1);
        chk("t3_no_bytes", bytes_q.size(), 0);

        // 4: address wrap past 0xFF
        do_reset();
        res_base = 8'hFE; res_count = 3;
        trig(4'hF);
        wait_done("t4_done");
        chk_bytes("t4", '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03});
        chk("t4_addr0", addr_q[0], 8'hFE);
        chk("t4_addr2", addr_q[2], 8'hFF);
        chk("t4_addr4", addr_q[4], 8'h00);

        // 5: reset during the first low byte, then a clean restart
        do_reset();
        res_base = 8'h40; res_count = 4;
        trig(4'hF);
        step(4);
        chk("t5_in_lo", tx_data, 8'h11);
        do_reset();
        chk("t5_rst_valid", tx_valid, 0);
        chk("t5_rst_sel", mem_sel, 0);
        chk("t5_rst_done", done, 0);
        step(3);
        chk("t5_idle_sel", mem_sel, 0);
        trig(4'hF);
        wait_done("t5_done");
        chk_bytes("t5", '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44});

        // 6: one core never finishes
        do_reset();
        trig(4'b0001); step(2);
        trig(4'b0100); step(2);
        trig(4'b0010);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (mem_sel !== 0 || tx_valid !== 0 || done !== 0) bad = 1;
            step(1);
        end
        chk("t6_stay_idle", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
